// File: rtl/cla_pipe_adder.sv
// rtl/cla_pipe_adder.sv - two-stage pipelined carry-lookahead adder/subtractor with valid/ready handshake.
// Define CLA_PIPE_SAT_EN to saturate sum_o to the signed extreme on overflow.
module cla_pipe_adder #(
  parameter int WIDTH = 64,
  parameter int GROUP = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             cin_i,
  input  logic             sub_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] sum_o,
  output logic             cout_o,
  output logic             ovf_o,
  output logic             zero_o
);

  localparam int NG = WIDTH / GROUP;

  logic             s1_valid;
  logic [WIDTH-1:0] s1_p, s1_g;
  logic [NG-1:0]    s1_gp, s1_gg;
  logic             s1_cin;
`ifdef CLA_PIPE_SAT_EN
  logic             s1_sign;
`endif

  logic             s2_load;
  logic [WIDTH-1:0] b_eff, p_d, g_d;
  logic [NG-1:0]    gp_d, gg_d;
  logic             cin_d;

  assign s2_load    = ~out_valid_o | out_ready_i;
  assign in_ready_o = ~s1_valid | s2_load;

  // Stage 1: per-bit propagate/generate and 4-bit group lookahead terms.
  always_comb begin
    b_eff = sub_i ? ~b_i : b_i;
    p_d   = a_i ^ b_eff;
    g_d   = a_i & b_eff;
    cin_d = sub_i | cin_i;
    gp_d  = '0;
    gg_d  = '0;
    for (int k = 0; k < NG; k++) begin
      gp_d[k] = &p_d[k*GROUP +: GROUP];
      gg_d[k] = g_d[k*GROUP+3]
              | (p_d[k*GROUP+3] & g_d[k*GROUP+2])
              | (p_d[k*GROUP+3] & p_d[k*GROUP+2] & g_d[k*GROUP+1])
              | (p_d[k*GROUP+3] & p_d[k*GROUP+2] & p_d[k*GROUP+1] & g_d[k*GROUP]);
    end
  end

  logic [NG:0]      gc;
  logic [WIDTH-1:0] c;
  logic [WIDTH-1:0] sum_d;
  logic             cout_d, ovf_d, zero_d;
  logic             acc, prod, cr;

  // Stage 2: group carries as a flat sum-of-products over the group P/G.
  always_comb begin
    gc   = '0;
    c    = '0;
    acc  = 1'b0;
    prod = 1'b1;
    cr   = 1'b0;
    for (int k = 0; k <= NG; k++) begin
      acc  = 1'b0;
      prod = 1'b1;
      for (int j = NG - 1; j >= 0; j--) begin
        if (j < k) begin
          acc  = acc | (prod & s1_gg[j]);
          prod = prod & s1_gp[j];
        end
      end
      gc[k] = acc | (prod & s1_cin);
    end
    for (int k = 0; k < NG; k++) begin
      cr = gc[k];
      for (int i = 0; i < GROUP; i++) begin
        c[k*GROUP+i] = cr;
        cr = s1_g[k*GROUP+i] | (s1_p[k*GROUP+i] & cr);
      end
    end
    sum_d  = s1_p ^ c;
    cout_d = gc[NG];
    ovf_d  = gc[NG] ^ c[WIDTH-1];
`ifdef CLA_PIPE_SAT_EN
    if (ovf_d) begin
      sum_d = s1_sign ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end
`endif
    zero_d = (sum_d == '0);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      s1_valid    <= 1'b0;
      s1_p        <= '0;
      s1_g        <= '0;
      s1_gp       <= '0;
      s1_gg       <= '0;
      s1_cin      <= 1'b0;
`ifdef CLA_PIPE_SAT_EN
      s1_sign     <= 1'b0;
`endif
      out_valid_o <= 1'b0;
      sum_o       <= '0;
      cout_o      <= 1'b0;
      ovf_o       <= 1'b0;
      zero_o      <= 1'b0;
    end else begin
      if (in_ready_o) begin
        s1_valid <= in_valid_i;
        if (in_valid_i) begin
          s1_p    <= p_d;
          s1_g    <= g_d;
          s1_gp   <= gp_d;
          s1_gg   <= gg_d;
          s1_cin  <= cin_d;
`ifdef CLA_PIPE_SAT_EN
          s1_sign <= a_i[WIDTH-1];
`endif
        end
      end
      // Output register holds while stalled; advances only when empty or draining.
      if (s2_load) begin
        out_valid_o <= s1_valid;
        if (s1_valid) begin
          sum_o  <= sum_d;
          cout_o <= cout_d;
          ovf_o  <= ovf_d;
          zero_o <= zero_d;
        end
      end
    end
  end

endmodule

// File: tb/tb_cla_pipe_adder.sv
// tb/tb_cla_pipe_adder.sv - self-checking bench for cla_pipe_adder against an arithmetic reference model.
module tb_cla_pipe_adder;
  localparam int W = 64;
  typedef logic [W+2:0] res_t;

  logic         clk = 1'b0;
  logic         rst, in_valid, in_ready, cin, sub, out_valid, out_ready, cout, ovf, zero;
  logic [W-1:0] a, b, sum;

  int   tests = 0;
  int   fails = 0;
  res_t q[$];

  cla_pipe_adder #(.WIDTH(W), .GROUP(4)) dut (
    .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .in_ready_o(in_ready),
    .a_i(a), .b_i(b), .cin_i(cin), .sub_i(sub),
    .out_valid_o(out_valid), .out_ready_i(out_ready),
    .sum_o(sum), .cout_o(cout), .ovf_o(ovf), .zero_o(zero)
  );

  always #5 clk = ~clk;

  function automatic res_t model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                 input logic mc, input logic ms);
    logic [W-1:0] bb, s;
    logic [W:0]   full;
    logic         ov;
    bb   = ms ? ~mb : mb;
    full = {1'b0, ma} + {1'b0, bb} + {{W{1'b0}}, (ms ? 1'b1 : mc)};
    s    = full[W-1:0];
    ov   = (ma[W-1] == bb[W-1]) && (s[W-1] != ma[W-1]);
`ifdef CLA_PIPE_SAT_EN
    if (ov) s = ma[W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
`endif
    return {s, full[W], ov, (s == '0)};
  endfunction

  task automatic check(input string nm, input res_t act, input res_t exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      q.delete();
    end else begin
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL spurious_output: got sum %h expected no output", sum);
        end else begin
          check("model_compare", {sum, cout, ovf, zero}, q.pop_front());
        end
      end
      if (in_valid && in_ready) q.push_back(model(a, b, cin, sub));
    end
  end

  task automatic send_one(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic tc,
                          input logic ts, input res_t exp, input string nm);
    @(posedge clk); #1;
    a = ta; b = tb_; cin = tc; sub = ts; in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk); check({nm, "_ready"}, in_ready, 1);
    @(posedge clk); #1 in_valid = 1'b0;
    @(negedge clk); check({nm, "_lat1"}, out_valid, 0);
    @(negedge clk); check({nm, "_lat2"}, out_valid, 1);
    check(nm, {sum, cout, ovf, zero}, exp);
  endtask

  function automatic logic [W-1:0] rnd();
    case ($urandom_range(5))
      0:       return '0;
      1:       return '1;
      2:       return {1'b0, {(W-1){1'b1}}};
      3:       return {1'b1, {(W-1){1'b0}}};
      default: return {$urandom, $urandom};
    endcase
  endfunction

  localparam logic [W-1:0] MAXP = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0] MINN = {1'b1, {(W-1){1'b0}}};

  initial begin
    int  accepted;
    int  guard;
    bit  acc;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0;

    check("pin_model_sub_neg", model(64'd5, 64'd7, 1'b0, 1'b1), {64'hFFFF_FFFF_FFFF_FFFE, 3'b000});
    check("pin_model_wrap", model('1, 64'd0, 1'b1, 1'b0), {64'd0, 3'b101});

    repeat (2) @(negedge clk);
    check("reset_outputs", {sum, cout, ovf, zero, out_valid}, '0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk); check("reset_ready", in_ready, 1);

    send_one('1, 64'd0, 1'b1, 1'b0, {64'd0, 3'b101}, "wrap_all_ones");
`ifdef CLA_PIPE_SAT_EN
    send_one(MAXP, 64'd1, 1'b0, 1'b0, {MAXP, 3'b010}, "pos_ovf");
    send_one(MINN, 64'd1, 1'b0, 1'b1, {MINN, 3'b110}, "neg_ovf");
`else
    send_one(MAXP, 64'd1, 1'b0, 1'b0, {MINN, 3'b010}, "pos_ovf");
    send_one(MINN, 64'd1, 1'b0, 1'b1, {MAXP, 3'b110}, "neg_ovf");
`endif
    send_one(64'd5, 64'd7, 1'b0, 1'b1, {64'hFFFF_FFFF_FFFF_FFFE, 3'b000}, "sub_5_7");
    send_one(64'd7, 64'd5, 1'b0, 1'b1, {64'd2, 3'b100}, "sub_7_5");
    send_one(64'd7, 64'd5, 1'b1, 1'b1, {64'd2, 3'b100}, "sub_cin_ignored");
    send_one(64'd0, 64'd0, 1'b0, 1'b1, {64'd0, 3'b101}, "sub_0_0");
    send_one(64'd100, 64'd23, 1'b1, 1'b0, {64'd124, 3'b000}, "add_cin");

    // Back-to-back accepts with the output stalled.
    @(posedge clk); #1;
    out_ready = 1'b0; a = 64'd1; b = 64'd1; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
    @(negedge clk); check("bb_accept1", in_ready, 1);
    @(posedge clk); #1 a = 64'd2; b = 64'd2;
    @(negedge clk); check("bb_accept2", in_ready, 1);
    @(posedge clk); #1 a = 64'd3; b = 64'd3;
    @(negedge clk); check("bb_ready_falls", in_ready, 0);
    check("bb_stall0", {sum, out_valid}, {64'd2, 1'b1});
    for (int i = 1; i < 3; i++) begin
      @(negedge clk);
      check("bb_stall_hold", {sum, out_valid, in_ready}, {64'd2, 1'b1, 1'b0});
    end
    @(posedge clk); #1 out_ready = 1'b1;
    @(negedge clk); check("bb_out2", {sum, out_valid, in_ready}, {64'd2, 1'b1, 1'b1});
    @(posedge clk); #1 in_valid = 1'b0;
    @(negedge clk); check("bb_out4", {sum, out_valid}, {64'd4, 1'b1});
    @(negedge clk); check("bb_out6", {sum, out_valid}, {64'd6, 1'b1});
    @(negedge clk); check("bb_empty", out_valid, 0);

    // Reset with two transactions in flight.
    @(posedge clk); #1;
    out_ready = 1'b0; a = 64'd10; b = 64'd1; in_valid = 1'b1;
    @(posedge clk); #1 a = 64'd20;
    @(posedge clk); #1 in_valid = 1'b0;
    check("pre_reset_valid", out_valid, 1);
    rst = 1'b1;
    #1 check("reset_immediate", {sum, cout, ovf, zero, out_valid}, '0);
    @(negedge clk);
    @(posedge clk); #1 rst = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); check("no_stale", out_valid, 0);
    end
    send_one(64'd40, 64'd2, 1'b0, 1'b0, {64'd42, 3'b000}, "post_reset");

    // Randomised operands and handshakes.
    accepted = 0; guard = 0; acc = 1'b0;
    while (accepted < 10000 && guard < 60000) begin
      @(posedge clk); #1;
      if (!in_valid || acc) begin
        in_valid = ($urandom_range(3) != 0);
        a = rnd(); b = rnd(); cin = 1'($urandom); sub = 1'($urandom);
      end
      out_ready = ($urandom_range(3) != 0);
      @(negedge clk);
      acc = in_valid && in_ready;
      if (acc) accepted++;
      guard++;
    end
    check("random_budget", accepted, 10000);
    @(posedge clk); #1 in_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 10 && q.size() != 0; i++) @(negedge clk);
    check("drain_empty", q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/cla_pipe_adder.md
CLA_PIPE_ADDER -- requirements
Module: cla_pipe_adder

Interface
REQ-001 The block SHALL have parameter WIDTH, default 64, meaning operand width in bits (a multiple of 4, 8..128).
REQ-002 The block SHALL have parameter GROUP, default 4, meaning bits per lookahead group (fixed 4; WIDTH/GROUP groups).
REQ-003 Port clk_i, in, 1: the single clock; all state updates on its rising edge.
REQ-004 Port rst_i, in, 1: asynchronous, active-high reset.
REQ-005 Port in_valid_i, in, 1: the input operands are valid.
REQ-006 Port in_ready_o, out, 1: the block accepts input this cycle.
REQ-007 Port a_i, in, WIDTH: operand A.
REQ-008 Port b_i, in, WIDTH: operand B.
REQ-009 Port cin_i, in, 1: carry-in, used when sub_i=0.
REQ-010 Port sub_i, in, 1: 1 = A-B (B inverted, carry-in forced to 1, cin_i ignored).
REQ-011 Port out_valid_o, out, 1: the result is valid.
REQ-012 Port out_ready_i, in, 1: downstream accepts the result.
REQ-013 Port sum_o, out, WIDTH: result.
REQ-014 Port cout_o, out, 1: carry-out of the MSB (for subtraction, 1 = no borrow).
REQ-015 Port ovf_o, out, 1: signed two's-complement overflow.
REQ-016 Port zero_o, out, 1: sum_o equals 0.

Function
REQ-017 Stage 1 SHALL register per-bit p=a^b', g=a&b', the effective carry-in, and per-group P/G (4-bit lookahead equations).
- b' = ~b_i when sub_i=1, else b_i.
REQ-018 Stage 2 SHALL compute group carries by a second lookahead level over the group P/G, then the bit carries, sum, cout, ovf and zero, and register all outputs.
REQ-019 Latency SHALL be exactly 2 cycles from input acceptance (in_valid_i & in_ready_o) to out_valid_o=1, with throughput of one result per cycle when unstalled.
REQ-020 Each stage register SHALL load when it is empty or its contents are leaving the same cycle.
- in_ready_o = ~s1_valid | s2_load.
- s2_load = ~out_valid_o | out_ready_i.
- in_ready_o SHALL be a function of state and out_ready_i only, never of in_valid_i.
REQ-021 While out_valid_o=1 and out_ready_i=0, sum_o, cout_o, ovf_o and zero_o SHALL hold stable and no transaction SHALL be lost or duplicated.
REQ-022 An accept while stage 1 is full and stage 2 drains in the same cycle SHALL shift both stages simultaneously.
REQ-023 Results SHALL emerge in acceptance order.
REQ-024 sum_o and cout_o SHALL equal A + B' + cin_eff modulo 2^WIDTH, with the carry out of bit WIDTH-1 driven on cout_o.
REQ-025 ovf_o SHALL equal the carry into the MSB XOR the carry out of the MSB.
REQ-026 Wrap-around SHALL occur silently: all-ones + 1 gives sum 0, cout 1, zero 1.
REQ-027 in_valid_i=0 SHALL leave stage 1 empty; bubbles SHALL propagate without producing output.

Reset
REQ-028 rst_i=1 SHALL immediately clear both stage valid bits.
- Outputs: out_valid_o=0, sum_o=0, cout_o=0, ovf_o=0, zero_o=0.
- in_ready_o=1 after release.
REQ-029 Reset mid-operation SHALL discard all in-flight transactions; the first accept after release SHALL produce a result exactly 2 cycles later.

Configuration
REQ-030 The block SHALL honour macro CLA_PIPE_SAT_EN.
- Defined: when ovf_o=1, sum_o SHALL saturate to the signed extreme (0x7F..F if the A sign bit is 0, else 0x80..0), zero_o SHALL be evaluated on the saturated value, and ovf_o SHALL still report 1.
- Undefined: sum_o SHALL be the wrapped result per REQ-024.

Verification (WIDTH=64)
REQ-031 a=0xFFFF_FFFF_FFFF_FFFF, b=0, cin=1, sub=0 -> sum=0, cout=1, zero=1, ovf=0, valid 2 cycles after accept.
REQ-032 a=0x7FFF_FFFF_FFFF_FFFF, b=1, sub=0 -> ovf=1; sum=0x8000_0000_0000_0000 without CLA_PIPE_SAT_EN, 0x7FFF_FFFF_FFFF_FFFF with it.
REQ-033 a=5, b=7, sub=1 -> sum=0xFFFF_FFFF_FFFF_FFFE, cout=0, ovf=0; a=7, b=5, sub=1 -> sum=2, cout=1.
REQ-034 Back-to-back accepts of 1+1, 2+2 and 3+3 with out_ready_i held 0 for 3 cycles -> in_ready_o falls after 2 accepts, sum_o holds 2, then 2, 4, 6 are delivered in order with none lost.
REQ-035 Assert rst_i with 2 transactions in flight -> out_valid_o=0 immediately, and no stale result appears after release.
REQ-036 10k random operands and handshakes checked against a reference model (A+B'+cin) -> zero mismatches and order preserved.
